// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// UART transmitter with a byte FIFO in front of it. Producers push bytes with
// a valid/ready handshake; the serialiser drains the FIFO and emits frames of
// START, DATA_BITS data bits (LSB first), optional parity and STOP_BITS stop
// bits. Frames are sent back-to-back with no idle cycle while data is queued
// and the (synchronised) clear-to-send input is asserted.
//
// Ports
//   clk_i         system clock, rising edge
//   rst_i         asynchronous active-high reset
//   data_i        byte to enqueue (only [DATA_BITS-1:0] reach the line)
//   valid_i       data_i valid
//   ready_o       FIFO not full; a push happens on valid_i && ready_o
//   baud_div_i    clocks per bit, sampled at each frame start (<2 -> DEF_DIV)
//   cts_ni        clear-to-send, active low, asynchronous to clk_i
//   tx_o          serial line, idle high (registered)
//   busy_o        high while a frame is on the line (registered)
//   fifo_level_o  bytes queued, not counting the byte being shifted out
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DEF_DIV    = CLK_HZ / BAUD_RATE,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [7:0]       data_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [15:0]      baud_div_i,
  input  logic             cts_ni,
  output logic             tx_o,
  output logic             busy_o,
  output logic [LVL_W-1:0] fifo_level_o
);

  localparam int               PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);
  localparam logic [15:0]      DEF_DIV_W = 16'(DEF_DIV);
  localparam logic [2:0]       LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  // Parity over the transmitted data bits only; bits above DATA_BITS are
  // masked so that unused upper bits of data_i never affect the line.
  function automatic logic calc_parity(input logic [7:0] data);
    logic [7:0] mask;
    logic       even;
    mask = 8'((9'd1 << DATA_BITS) - 9'd1);
    even = ^(data & mask);
    return (PARITY == 2) ? ~even : even;
  endfunction

  // FIFO
  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;

  // CTS synchroniser
  logic cts_meta_r;
  logic cts_sync_r;

  // Serialiser
  state_e      state_r;
  logic [7:0]  shift_r;
  logic        parity_r;
  logic [15:0] div_r;
  logic [15:0] baud_cnt_r;
  logic [2:0]  bit_cnt_r;
  logic        stop_cnt_r;
  logic        tx_r;
  logic        busy_r;

  // Combinational helpers
  logic        push_s;
  logic        pop_s;
  logic        can_start_s;
  logic        bit_end_s;
  logic [7:0]  head_s;
  logic [15:0] new_div_s;

  assign head_s      = mem_r[rd_ptr_r];
  // ready_o depends on the registered level only, never on valid_i
  assign ready_o     = (level_r != FULL_LVL);
  assign push_s      = valid_i && ready_o;
  assign can_start_s = (level_r != {LVL_W{1'b0}}) && !cts_sync_r;
  assign bit_end_s   = (baud_cnt_r == (div_r - 16'd1));
  assign new_div_s   = (baud_div_i < 16'd2) ? DEF_DIV_W : baud_div_i;

  assign tx_o         = tx_r;
  assign busy_o       = busy_r;
  assign fifo_level_o = level_r;

  // Pop decision: a new frame starts only from IDLE or at the very end of the
  // last stop bit, so CTS is only ever honoured on frame boundaries.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      ST_IDLE: pop_s = can_start_s;
      ST_STOP: pop_s = bit_end_s && (stop_cnt_r == STOP_LAST) && can_start_s;
      default: pop_s = 1'b0;
    endcase
  end

  // Two-flop synchroniser for cts_ni; resets to the "not clear" level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cts_meta_r <= 1'b1;
      cts_sync_r <= 1'b1;
    end else begin
      cts_meta_r <= cts_ni;
      cts_sync_r <= cts_meta_r;
    end
  end

  // FIFO storage; contents need no reset because the level qualifies reads.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= data_i;
    end
  end

  // FIFO pointers and level; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Transmit FSM with registered tx/busy. Each bit lasts div_r cycles:
  // baud_cnt_r runs 0..div_r-1 and the bit advances on the last count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      shift_r    <= 8'h00;
      parity_r   <= 1'b0;
      div_r      <= DEF_DIV_W;
      baud_cnt_r <= 16'd0;
      bit_cnt_r  <= 3'd0;
      stop_cnt_r <= 1'b0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
    end else if (pop_s) begin
      // Frame start, either from IDLE or directly after the last stop bit.
      // The divisor is captured here so mid-frame changes wait a frame.
      state_r    <= ST_START;
      shift_r    <= head_s;
      parity_r   <= calc_parity(head_s);
      div_r      <= new_div_s;
      baud_cnt_r <= 16'd0;
      bit_cnt_r  <= 3'd0;
      stop_cnt_r <= 1'b0;
      tx_r       <= 1'b0;
      busy_r     <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          tx_r       <= 1'b1;
          busy_r     <= 1'b0;
          baud_cnt_r <= 16'd0;
        end

        ST_START: begin
          if (bit_end_s) begin
            state_r    <= ST_DATA;
            tx_r       <= shift_r[0];
            shift_r    <= {1'b0, shift_r[7:1]};
            bit_cnt_r  <= 3'd0;
            baud_cnt_r <= 16'd0;
          end else begin
            baud_cnt_r <= baud_cnt_r + 16'd1;
          end
        end

        ST_DATA: begin
          if (bit_end_s) begin
            baud_cnt_r <= 16'd0;
            if (bit_cnt_r == LAST_DATA) begin
              if (PARITY != 0) begin
                state_r <= ST_PARITY;
                tx_r    <= parity_r;
              end else begin
                state_r    <= ST_STOP;
                tx_r       <= 1'b1;
                stop_cnt_r <= 1'b0;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
              tx_r      <= shift_r[0];
              shift_r   <= {1'b0, shift_r[7:1]};
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + 16'd1;
          end
        end

        ST_PARITY: begin
          if (bit_end_s) begin
            state_r    <= ST_STOP;
            tx_r       <= 1'b1;
            stop_cnt_r <= 1'b0;
            baud_cnt_r <= 16'd0;
          end else begin
            baud_cnt_r <= baud_cnt_r + 16'd1;
          end
        end

        ST_STOP: begin
          if (bit_end_s) begin
            baud_cnt_r <= 16'd0;
            if (stop_cnt_r == STOP_LAST) begin
              // No follow-on frame (a follow-on is handled by pop_s above).
              state_r <= ST_IDLE;
              tx_r    <= 1'b1;
              busy_r  <= 1'b0;
            end else begin
              stop_cnt_r <= stop_cnt_r + 1'b1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + 16'd1;
          end
        end

        default: begin
          state_r    <= ST_IDLE;
          tx_r       <= 1'b1;
          busy_r     <= 1'b0;
          baud_cnt_r <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Directed bench for uart_tx_fifo. Three instances share clock and reset:
//   dut_a : 8 data bits, no parity, 1 stop, DEF_DIV = 10, FIFO_DEPTH = 4
//   dut_b : 7 data bits, even parity, 2 stop, DEF_DIV = 10
//   dut_c : 7 data bits, odd parity, 2 stop, DEF_DIV = 10
// Expected line waveforms are built from the byte and frame format; every
// cycle of every bit is compared on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic rst;

  logic [7:0]  data_a;
  logic        valid_a;
  logic        ready_a;
  logic [15:0] baud_a;
  logic        cts_a;
  logic        tx_a;
  logic        busy_a;
  logic [2:0]  level_a;

  logic [7:0]  data_bc;
  logic        valid_bc;
  logic [15:0] baud_bc;
  logic        cts_bc;
  logic        ready_b, tx_b, busy_b;
  logic        ready_c, tx_c, busy_c;
  logic [4:0]  level_b, level_c;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] q_bytes [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLK_HZ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0),
    .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .data_i(data_a), .valid_i(valid_a),
    .ready_o(ready_a), .baud_div_i(baud_a), .cts_ni(cts_a), .tx_o(tx_a),
    .busy_o(busy_a), .fifo_level_o(level_a)
  );

  uart_tx_fifo #(
    .CLK_HZ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(1),
    .STOP_BITS(2), .FIFO_DEPTH(16)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .data_i(data_bc), .valid_i(valid_bc),
    .ready_o(ready_b), .baud_div_i(baud_bc), .cts_ni(cts_bc), .tx_o(tx_b),
    .busy_o(busy_b), .fifo_level_o(level_b)
  );

  uart_tx_fifo #(
    .CLK_HZ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(2),
    .STOP_BITS(2), .FIFO_DEPTH(16)
  ) dut_c (
    .clk_i(clk), .rst_i(rst), .data_i(data_bc), .valid_i(valid_bc),
    .ready_o(ready_c), .baud_div_i(baud_bc), .cts_ni(cts_bc), .tx_o(tx_c),
    .busy_o(busy_c), .fifo_level_o(level_c)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic tx_of(input int w);
    case (w)
      0:       return tx_a;
      1:       return tx_b;
      default: return tx_c;
    endcase
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  // Waits (bounded) for the start bit, checks how many falling edges that
  // took, then checks every cycle of every bit plus busy during the frame.
  // Returns at the falling edge of the last cycle of the last stop bit.
  task automatic check_frame(input int w, input logic [7:0] d, input int dbits,
                             input int par, input int stops, input int div,
                             input int exp_wait, input string tag);
    logic exp_bits [0:11];
    int   nb;
    int   n;
    int   bad;
    int   busy_bad;
    logic p;
    nb = 0;
    exp_bits[nb] = 1'b0;
    nb++;
    p = 1'b0;
    for (int i = 0; i < dbits; i++) begin
      exp_bits[nb] = d[i];
      p = p ^ d[i];
      nb++;
    end
    if (par == 1) begin
      exp_bits[nb] = p;
      nb++;
    end else if (par == 2) begin
      exp_bits[nb] = ~p;
      nb++;
    end
    for (int i = 0; i < stops; i++) begin
      exp_bits[nb] = 1'b1;
      nb++;
    end
    n = 0;
    while (tx_of(w) !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_start_wait"}, n, exp_wait);
    busy_bad = 0;
    for (int b = 0; b < nb; b++) begin
      bad = 0;
      for (int c = 0; c < div; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (tx_of(w) !== exp_bits[b]) bad++;
        if (busy_of(w) !== 1'b1) busy_bad++;
      end
      check_eq($sformatf("%s_bit%0d", tag, b), bad, 0);
    end
    check_eq({tag, "_busy"}, busy_bad, 0);
  endtask

  task automatic check_idle_a(input string tag);
    @(negedge clk);
    check_eq({tag, "_idle_tx"}, tx_a, 1'b1);
    check_eq({tag, "_idle_busy"}, busy_a, 1'b0);
  endtask

  initial begin
    int idle_bad;
    rst      = 1'b1;
    data_a   = 8'h00;
    valid_a  = 1'b0;
    baud_a   = 16'd0;
    cts_a    = 1'b1;
    data_bc  = 8'h00;
    valid_bc = 1'b0;
    baud_bc  = 16'd0;
    cts_bc   = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_tx", tx_a, 1'b1);
    check_eq("rst_busy", busy_a, 1'b0);
    check_eq("rst_ready", ready_a, 1'b1);
    check_eq("rst_level", level_a, 3'd0);
    check_eq("rst_tx_b", tx_b, 1'b1);
    check_eq("rst_ready_c", ready_c, 1'b1);

    rst    = 1'b0;
    cts_a  = 1'b0;
    cts_bc = 1'b0;
    repeat (4) @(negedge clk);

    // Single byte 0xA5 at default divisor; pop one edge after the push
    data_a  = 8'hA5;
    valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    check_eq("a5_level", level_a, 3'd1);
    check_eq("a5_tx_pre", tx_a, 1'b1);
    check_frame(0, 8'hA5, 8, 0, 1, 10, 1, "a5");
    check_idle_a("a5");

    // Fill a depth-4 FIFO with CTS deasserted, then release CTS
    cts_a = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      data_a  = q_bytes[i];
      valid_a = 1'b1;
      check_eq($sformatf("full_ready%0d", i), ready_a, (i < 4) ? 1'b1 : 1'b0);
      @(negedge clk);
    end
    valid_a = 1'b0;
    check_eq("full_level", level_a, 3'd4);
    check_eq("full_ready", ready_a, 1'b0);
    check_eq("full_tx", tx_a, 1'b1);
    cts_a = 1'b0;
    check_frame(0, 8'h11, 8, 0, 1, 10, 3, "q0");
    check_eq("q0_level", level_a, 3'd3);
    check_eq("q0_ready", ready_a, 1'b1);
    check_frame(0, 8'h22, 8, 0, 1, 10, 1, "q1");
    check_frame(0, 8'h33, 8, 0, 1, 10, 1, "q2");
    check_frame(0, 8'h44, 8, 0, 1, 10, 1, "q3");
    check_idle_a("q3");
    check_eq("q_level_end", level_a, 3'd0);

    // Divisor 4, changed to 7 during the frame; then divisor 1 -> default
    baud_a  = 16'd4;
    data_a  = 8'h3C;
    valid_a = 1'b1;
    @(negedge clk);
    data_a = 8'hC3;
    @(negedge clk);
    valid_a = 1'b0;
    check_eq("div_pushpop_level", level_a, 3'd1);
    baud_a = 16'd7;
    check_frame(0, 8'h3C, 8, 0, 1, 4, 0, "div4");
    check_frame(0, 8'hC3, 8, 0, 1, 7, 1, "div7");
    check_idle_a("div7");
    baud_a  = 16'd1;
    data_a  = 8'h81;
    valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    check_frame(0, 8'h81, 8, 0, 1, 10, 1, "div1");
    check_idle_a("div1");
    baud_a = 16'd0;

    // CTS raised during data bit 3: frame completes, next one is withheld
    data_a  = 8'h5A;
    valid_a = 1'b1;
    @(negedge clk);
    data_a = 8'h96;
    @(negedge clk);
    valid_a = 1'b0;
    fork
      check_frame(0, 8'h5A, 8, 0, 1, 10, 0, "cts0");
      begin
        repeat (45) @(negedge clk);
        cts_a = 1'b1;
      end
    join
    idle_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) idle_bad++;
    end
    check_eq("cts_hold", idle_bad, 0);
    check_eq("cts_hold_level", level_a, 3'd1);
    cts_a = 1'b0;
    check_frame(0, 8'h96, 8, 0, 1, 10, 3, "cts1");
    check_idle_a("cts1");

    // 7 data bits, even/odd parity, 2 stop bits; bit 7 of 0xD3 is dropped
    data_bc  = 8'h53;
    valid_bc = 1'b1;
    @(negedge clk);
    data_bc = 8'hD3;
    @(negedge clk);
    valid_bc = 1'b0;
    fork
      begin
        check_frame(1, 8'h53, 7, 1, 2, 10, 0, "even0");
        check_frame(1, 8'hD3, 7, 1, 2, 10, 1, "even1");
      end
      begin
        check_frame(2, 8'h53, 7, 2, 2, 10, 0, "odd0");
        check_frame(2, 8'hD3, 7, 2, 2, 10, 1, "odd1");
      end
    join
    @(negedge clk);
    check_eq("bc_idle_tx_b", tx_b, 1'b1);
    check_eq("bc_idle_busy_c", busy_c, 1'b0);
    check_eq("bc_level_b", level_b, 5'd0);
    check_eq("bc_level_c", level_c, 5'd0);

    // Asynchronous reset mid-DATA with three bytes queued
    data_a  = 8'hF0;
    valid_a = 1'b1;
    @(negedge clk);
    data_a = 8'h0F;
    @(negedge clk);
    data_a = 8'h33;
    @(negedge clk);
    data_a = 8'hCC;
    @(negedge clk);
    valid_a = 1'b0;
    check_eq("mid_level", level_a, 3'd3);
    repeat (25) @(negedge clk);
    check_eq("mid_busy", busy_a, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("arst_tx", tx_a, 1'b1);
    check_eq("arst_busy", busy_a, 1'b0);
    check_eq("arst_level", level_a, 3'd0);
    check_eq("arst_ready", ready_a, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) idle_bad++;
    end
    check_eq("post_rst_quiet", idle_bad, 0);
    check_eq("post_rst_level", level_a, 3'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
